io_axil_timer: RTL and testbench
================================

IO_AXIL_TIMER -- requirements
Module: io_axil_timer

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, number of independent countdown timers (1..8).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width; only 32 is supported.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have write-address ports s_axi_awaddr (in, ADDR_WIDTH), s_axi_awprot (in, 3, ignored), s_axi_awvalid (in, 1) and s_axi_awready (out, 1).
REQ-007 SHALL have write-data ports s_axi_wdata (in, 32), s_axi_wstrb (in, 4), s_axi_wvalid (in, 1) and s_axi_wready (out, 1).
REQ-008 SHALL have write-response ports s_axi_bresp (out, 2), s_axi_bvalid (out, 1) and s_axi_bready (in, 1).
REQ-009 SHALL have read-address ports s_axi_araddr (in, ADDR_WIDTH), s_axi_arprot (in, 3, ignored), s_axi_arvalid (in, 1) and s_axi_arready (out, 1).
REQ-010 SHALL have read-data ports s_axi_rdata (out, 32), s_axi_rresp (out, 2), s_axi_rvalid (out, 1) and s_axi_rready (in, 1).
REQ-011 SHALL have port timer_irq, output, NUM_TIMERS, level interrupt per timer; connects to processor interrupt_req.

Function
REQ-012 SHALL decode addr[11:0] only; timer i registers at i*0x10: +0x0 LOAD (RW), +0x4 COUNT (RO), +0x8 CTRL (RW; bit0 EN, bit1 AUTO_RELOAD), +0xC STATUS (bit0 EXPIRED, write-1-to-clear).
REQ-013 Write FSM SHALL have states W_IDLE and W_RESP; in W_IDLE, awready=wready=1 only in a cycle where awvalid and wvalid are both 1, and the FSM moves to W_RESP.
REQ-014 In W_RESP, bvalid SHALL be 1 and bresp held stable until bready; then the FSM returns to W_IDLE. No new write is accepted while in W_RESP.
REQ-015 Read FSM SHALL have states R_IDLE and R_DATA; arready=1 in R_IDLE; an accepted address latches rdata/rresp and the FSM enters R_DATA, where rvalid=1 until rready.
REQ-016 Read and write FSMs SHALL be independent; both may complete in the same cycle.
REQ-017 Unmapped or reserved offsets SHALL return SLVERR (2'b10) with rdata=0, and writes to them have no effect; mapped accesses return OKAY (2'b00). Writes to COUNT SHALL be ignored with OKAY.
REQ-018 Writes to LOAD SHALL honour wstrb per byte. Writes to CTRL/STATUS SHALL take effect only when wstrb[0]=1.
REQ-019 A LOAD write SHALL also copy the resulting LOAD value into COUNT on the same clock edge.
REQ-020 Each tick while EN=1 and COUNT!=0, COUNT SHALL decrement by 1; on the 1->0 transition EXPIRED is set, and if AUTO_RELOAD=1 COUNT is set to LOAD instead of 0.
REQ-021 EN=1 with COUNT=0 SHALL hold COUNT at 0 and never set EXPIRED.
REQ-022 Clearing EN SHALL freeze COUNT; setting EN SHALL resume from the frozen value.
REQ-023 If expiry and a W1C of EXPIRED occur in the same cycle, EXPIRED SHALL end set.
REQ-024 If a LOAD write and a decrement occur in the same cycle, the LOAD write SHALL win.
REQ-025 timer_irq[i] SHALL equal registered EXPIRED[i], with 1-cycle latency from the expiry edge.

Reset
REQ-026 On reset assertion, all LOAD, COUNT, CTRL and STATUS registers SHALL clear to 0, the FSMs SHALL enter W_IDLE/R_IDLE, and awready, wready, bvalid, rvalid, bresp, rresp, rdata and timer_irq SHALL be 0.
REQ-027 Reset mid-transaction SHALL abandon the pending response; no bvalid/rvalid is produced after release for that transaction.

Configuration
REQ-028 With IO_TIMER_PRESCALE_EN defined, a global PRESCALE register (RW, bits[15:0]) SHALL exist at offset NUM_TIMERS*0x10, reset value 0.
REQ-029 With the macro defined, a tick occurs once every PRESCALE+1 clocks via a free-running 16-bit divider; a PRESCALE write restarts the divider at 0.
REQ-030 Without IO_TIMER_PRESCALE_EN, every clock SHALL be a tick, and offset NUM_TIMERS*0x10 SHALL be unmapped (SLVERR).

Verification
REQ-031 Write LOAD0=5, then CTRL0=0x1 -> COUNT0 reads 5,4,..; EXPIRED0 and timer_irq[0]=1 five ticks after EN; COUNT0 stays 0.
REQ-032 Write LOAD1=3 and CTRL1=0x3 -> timer_irq[1] asserts every 3 ticks; W1C STATUS1=1 in the expiry cycle -> EXPIRED1 remains 1.
REQ-033 Read offset 0xFF0 -> rresp=2'b10, rdata=0; write to 0xFF0 with bready held low 4 cycles -> bvalid held 4 cycles, bresp=2'b10, awready=0 throughout.
REQ-034 awvalid asserted 3 cycles before wvalid -> awready/wready both 0 until wvalid arrives, then both 1 for exactly 1 cycle.
REQ-035 LOAD0 write with wstrb=4'b0010, wdata=0x0000AB00 over LOAD0=0x11223344 -> LOAD0=COUNT0=0x1122AB44.
REQ-036 With IO_TIMER_PRESCALE_EN: PRESCALE=3, LOAD2=2, CTRL2=1 -> EXPIRED2 set after 8 clocks; assert reset mid-count -> all registers 0 and timer_irq=0.

Source files
------------

// File: rtl/io_axil_timer.sv
// io_axil_timer: AXI4-Lite slave exposing NUM_TIMERS independent countdown timers.
//
// Register map (addr[11:0] only, timer i at i*0x10):
//   +0x0 LOAD   RW  byte-strobed; a write also copies into COUNT
//   +0x4 COUNT  RO  writes ignored (OKAY)
//   +0x8 CTRL   RW  bit0 EN, bit1 AUTO_RELOAD (only when wstrb[0])
//   +0xC STATUS     bit0 EXPIRED, write-1-to-clear (only when wstrb[0])
//   NUM_TIMERS*0x10 PRESCALE RW bits[15:0], present only with IO_TIMER_PRESCALE_EN
// Anything else answers SLVERR, reads return 0.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*     AXI4-Lite write channels (awprot ignored)
//   s_axi_ar*/r*        AXI4-Lite read channels (arprot ignored)
//   timer_irq           per-timer level interrupt = EXPIRED bit
//
// Optional feature macro: IO_TIMER_PRESCALE_EN (global tick prescaler).

// One countdown timer: LOAD/COUNT/CTRL/EXPIRED state and its tick behaviour.
module io_axil_timer_lane (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_tick,
    input  logic        i_ld_we,
    input  logic        i_ctrl_we,
    input  logic        i_w1c,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    output logic [31:0] o_load,
    output logic [31:0] o_count,
    output logic [1:0]  o_ctrl,
    output logic        o_expired
);
    logic [31:0] r_load;
    logic [31:0] r_count;
    logic [1:0]  r_ctrl;
    logic        r_expired;
    logic [31:0] w_load_next;
    logic        w_dec;
    logic        w_expire;

    always_comb begin
        w_load_next = r_load;
        for (int b = 0; b < 4; b++) begin
            if (i_wstrb[b]) w_load_next[8*b +: 8] = i_wdata[8*b +: 8];
        end
    end

    // A LOAD write in the same cycle suppresses the decrement and hence any expiry.
    assign w_dec    = i_tick && r_ctrl[0] && (r_count != 32'd0) && !i_ld_we;
    assign w_expire = w_dec && (r_count == 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load    <= '0;
            r_count   <= '0;
            r_ctrl    <= '0;
            r_expired <= 1'b0;
        end else begin
            if (i_ld_we) begin
                r_load  <= w_load_next;
                r_count <= w_load_next;
            end else if (w_dec) begin
                r_count <= w_expire ? (r_ctrl[1] ? r_load : 32'd0) : (r_count - 32'd1);
            end
            if (i_ctrl_we) r_ctrl <= i_wdata[1:0];
            // Expiry beats a simultaneous W1C so the event is never lost.
            if (w_expire)   r_expired <= 1'b1;
            else if (i_w1c) r_expired <= 1'b0;
        end
    end

    assign o_load    = r_load;
    assign o_count   = r_count;
    assign o_ctrl    = r_ctrl;
    assign o_expired = r_expired;
endmodule

module io_axil_timer #(
    parameter int NUM_TIMERS         = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [NUM_TIMERS-1:0]           timer_irq
);
    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t r_wstate;
    rstate_t r_rstate;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic [NUM_TIMERS-1:0][31:0] w_load;
    logic [NUM_TIMERS-1:0][31:0] w_count;
    logic [NUM_TIMERS-1:0][1:0]  w_ctrl;
    logic [NUM_TIMERS-1:0]       w_expired;

    logic        w_tick;
    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [7:0]  w_widx;
    logic [1:0]  w_wreg;
    logic        w_wtim_hit;
    logic        w_wr_ok;
    logic [7:0]  w_ridx;
    logic [1:0]  w_rreg;
    logic        w_rtim_hit;
    logic [31:0] w_rd_data;
    logic        w_rd_ok;
    logic        w_unused;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot,
                        s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:12],
                        s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:12]};

    // Address and data must arrive together; both readies pulse in that one cycle.
    assign w_wr_fire     = (r_wstate == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
    assign s_axi_awready = w_wr_fire;
    assign s_axi_wready  = w_wr_fire;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;

    assign w_rd_fire     = (r_rstate == R_IDLE) && s_axi_arvalid;
    assign s_axi_arready = (r_rstate == R_IDLE);
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    assign timer_irq = w_expired;

    // Timer block decode: index in addr[11:4], register in addr[3:2], word aligned.
    assign w_widx     = s_axi_awaddr[11:4];
    assign w_wreg     = s_axi_awaddr[3:2];
    assign w_wtim_hit = (w_widx < 8'(NUM_TIMERS)) && (s_axi_awaddr[1:0] == 2'b00);
    assign w_ridx     = s_axi_araddr[11:4];
    assign w_rreg     = s_axi_araddr[3:2];
    assign w_rtim_hit = (w_ridx < 8'(NUM_TIMERS)) && (s_axi_araddr[1:0] == 2'b00);

`ifdef IO_TIMER_PRESCALE_EN
    localparam logic [11:0] PRE_OFF = 12'(NUM_TIMERS * 16);
    logic [15:0] r_prescale;
    logic [15:0] r_div;
    logic        w_wpre;

    assign w_wpre  = (s_axi_awaddr[11:0] == PRE_OFF);
    assign w_tick  = (r_div == r_prescale);
    assign w_wr_ok = w_wtim_hit || w_wpre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prescale <= '0;
            r_div      <= '0;
        end else if (w_wr_fire && w_wpre) begin
            if (s_axi_wstrb[0]) r_prescale[7:0]  <= s_axi_wdata[7:0];
            if (s_axi_wstrb[1]) r_prescale[15:8] <= s_axi_wdata[15:8];
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end
`else
    assign w_tick  = 1'b1;
    assign w_wr_ok = w_wtim_hit;
`endif

    for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_lane
        logic w_sel;
        assign w_sel = w_wr_fire && w_wtim_hit && (w_widx == 8'(gi));
        io_axil_timer_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .i_tick    (w_tick),
            .i_ld_we   (w_sel && (w_wreg == 2'd0)),
            .i_ctrl_we (w_sel && (w_wreg == 2'd2) && s_axi_wstrb[0]),
            .i_w1c     (w_sel && (w_wreg == 2'd3) && s_axi_wstrb[0] && s_axi_wdata[0]),
            .i_wdata   (s_axi_wdata),
            .i_wstrb   (s_axi_wstrb),
            .o_load    (w_load[gi]),
            .o_count   (w_count[gi]),
            .o_ctrl    (w_ctrl[gi]),
            .o_expired (w_expired[gi])
        );
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_ok   = 1'b0;
        if (w_rtim_hit) begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (w_ridx == 8'(i)) begin
                    w_rd_ok = 1'b1;
                    case (w_rreg)
                        2'd0:    w_rd_data = w_load[i];
                        2'd1:    w_rd_data = w_count[i];
                        2'd2:    w_rd_data = {30'b0, w_ctrl[i]};
                        default: w_rd_data = {31'b0, w_expired[i]};
                    endcase
                end
            end
        end
`ifdef IO_TIMER_PRESCALE_EN
        if (s_axi_araddr[11:0] == PRE_OFF) begin
            w_rd_ok   = 1'b1;
            w_rd_data = {16'b0, r_prescale};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_bvalid <= 1'b0;
            r_bresp  <= 2'b00;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_wr_fire) begin
                    r_wstate <= W_RESP;
                    r_bvalid <= 1'b1;
                    r_bresp  <= w_wr_ok ? 2'b00 : 2'b10;
                end
                W_RESP: if (s_axi_bready) begin
                    r_wstate <= W_IDLE;
                    r_bvalid <= 1'b0;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_rvalid <= 1'b0;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_rd_fire) begin
                    r_rstate <= R_DATA;
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rd_data;
                    r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
                end
                R_DATA: if (s_axi_rready) begin
                    r_rstate <= R_IDLE;
                    r_rvalid <= 1'b0;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_axil_timer.sv
// Directed bench for io_axil_timer (NUM_TIMERS=4). Inputs are driven 1 time unit
// after the rising edge, outputs sampled there as well. cyc counts rising edges.
module tb_io_axil_timer;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [3:0]  timer_irq;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int w_cyc    = 0;

    io_axil_timer #(.NUM_TIMERS(4), .C_S_AXI_ADDR_WIDTH(32), .C_S_AXI_DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
    endtask

    // Full write: w_cyc records the edge count at which the write was accepted.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [1:0] exp_resp, input string tag);
        int n;
        s_axi_awaddr = {20'b0, a}; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        #1;
        n = 0;
        while (!(s_axi_awready && s_axi_wready) && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        w_cyc = cyc;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_bvalid"}, {31'b0, s_axi_bvalid}, 32'd1);
        chk({tag, "_bresp"}, {30'b0, s_axi_bresp}, {30'b0, exp_resp});
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp_d,
                      input logic [1:0] exp_resp, input string tag);
        int n;
        s_axi_araddr = {20'b0, a}; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
        #1;
        n = 0;
        while (!s_axi_arready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk({tag, "_rvalid"}, {31'b0, s_axi_rvalid}, 32'd1);
        chk({tag, "_rdata"}, s_axi_rdata, exp_d);
        chk({tag, "_rresp"}, {30'b0, s_axi_rresp}, {30'b0, exp_resp});
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_irq(input int idx, input int budget, output int got);
        int n = 0;
        while (!timer_irq[idx] && n < budget) begin @(posedge clk); #1; n++; end
        chk("irq_wait", {31'b0, timer_irq[idx]}, 32'd1);
        got = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c0, got;
`ifdef IO_TIMER_PRESCALE_EN
        int p0, t1;
`endif
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        tick(3);
        chk("rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
        chk("rst_rvalid", {31'b0, s_axi_rvalid}, 32'd0);
        chk("rst_awready", {31'b0, s_axi_awready}, 32'd0);
        chk("rst_rdata", s_axi_rdata, 32'd0);
        chk("rst_irq", {28'b0, timer_irq}, 32'd0);
        reset = 1'b0;
        tick(2);

        // One-shot countdown on timer 0
        wr(12'h000, 32'd5, 4'hF, 2'b00, "t0_load");
        rd(12'h004, 32'd5, 2'b00, "t0_count_init");
        wr(12'h008, 32'd1, 4'hF, 2'b00, "t0_en");
        c0 = w_cyc;
        rd(12'h004, 32'd4, 2'b00, "t0_count_run1");
        rd(12'h004, 32'd2, 2'b00, "t0_count_run2");
        wait_irq(0, 20, got);
        chk("t0_expiry_latency", 32'(got - c0), 32'd5);
        rd(12'h00C, 32'd1, 2'b00, "t0_status");
        rd(12'h004, 32'd0, 2'b00, "t0_count_zero");
        tick(5);
        rd(12'h004, 32'd0, 2'b00, "t0_count_hold");
        wr(12'h00C, 32'd1, 4'hF, 2'b00, "t0_w1c");
        chk("t0_irq_cleared", {31'b0, timer_irq[0]}, 32'd0);
        tick(5);
        chk("t0_no_reexpire", {31'b0, timer_irq[0]}, 32'd0);
        wr(12'h008, 32'd0, 4'hF, 2'b00, "t0_dis");

        // Auto-reload on timer 1, W1C colliding with expiry
        wr(12'h010, 32'd3, 4'hF, 2'b00, "t1_load");
        wr(12'h018, 32'd3, 4'hF, 2'b00, "t1_en_ar");
        c0 = w_cyc;
        wait_irq(1, 20, got);
        chk("t1_first_expiry", 32'(got - c0), 32'd3);
        while (cyc < c0 + 5) begin @(posedge clk); #1; end
        wr(12'h01C, 32'd1, 4'hF, 2'b00, "t1_w1c_collide");
        chk("t1_w1c_vs_expiry", {31'b0, timer_irq[1]}, 32'd1);
        wr(12'h018, 32'd0, 4'hF, 2'b00, "t1_dis");
        wr(12'h01C, 32'd1, 4'hF, 2'b00, "t1_w1c");
        chk("t1_irq_cleared", {31'b0, timer_irq[1]}, 32'd0);
        tick(3);
        rd(12'h014, 32'd1, 2'b00, "t1_frozen");
        wr(12'h018, 32'd1, 4'hF, 2'b00, "t1_resume");
        c0 = w_cyc;
        wait_irq(1, 20, got);
        chk("t1_resume_expiry", 32'(got - c0), 32'd1);
        wr(12'h01C, 32'd1, 4'hF, 2'b00, "t1_w1c2");
        wr(12'h018, 32'd0, 4'hF, 2'b00, "t1_dis2");

        // Unmapped read, then unmapped write with stalled bready
        rd(12'hFF0, 32'd0, 2'b10, "unmapped_rd");
        s_axi_awaddr = 32'hFF0; s_axi_wdata = 32'hDEAD; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        #1;
        chk("unm_wr_accept", {31'b0, s_axi_awready}, 32'd1);
        @(posedge clk); #1;
        s_axi_awaddr = 32'h030; s_axi_wdata = 32'h77;
        for (int k = 0; k < 4; k++) begin
            chk("unm_bvalid_held", {31'b0, s_axi_bvalid}, 32'd1);
            chk("unm_bresp", {30'b0, s_axi_bresp}, 32'd2);
            chk("unm_awready_blocked", {31'b0, s_axi_awready}, 32'd0);
            if (k < 3) begin @(posedge clk); #1; end
        end
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        chk("unm_bvalid_done", {31'b0, s_axi_bvalid}, 32'd0);
        chk("next_wr_ready", {31'b0, s_axi_awready}, 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk("next_wr_bresp", {30'b0, s_axi_bresp}, 32'd0);
        chk("next_wr_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        rd(12'h030, 32'h77, 2'b00, "t3_load_after_stall");

        // awvalid leads wvalid by 3 cycles
        s_axi_awaddr = 32'h020; s_axi_wdata = 32'h1234; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("aw_early_awready", {31'b0, s_axi_awready}, 32'd0);
            chk("aw_early_wready", {31'b0, s_axi_wready}, 32'd0);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b1;
        #1;
        chk("aw_join_awready", {31'b0, s_axi_awready}, 32'd1);
        chk("aw_join_wready", {31'b0, s_axi_wready}, 32'd1);
        @(posedge clk); #1;
        chk("aw_one_cycle_awready", {31'b0, s_axi_awready}, 32'd0);
        chk("aw_one_cycle_wready", {31'b0, s_axi_wready}, 32'd0);
        chk("aw_join_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        chk("aw_join_bdone", {31'b0, s_axi_bvalid}, 32'd0);
        s_axi_bready = 1'b0;
        rd(12'h020, 32'h1234, 2'b00, "t2_load_join");

        // Byte strobes, read-only COUNT, CTRL strobe gating
        wr(12'h000, 32'h11223344, 4'hF, 2'b00, "t0_load_full");
        wr(12'h000, 32'h0000AB00, 4'b0010, 2'b00, "t0_load_byte1");
        rd(12'h000, 32'h1122AB44, 2'b00, "t0_load_merged");
        rd(12'h004, 32'h1122AB44, 2'b00, "t0_count_merged");
        wr(12'h004, 32'h99, 4'hF, 2'b00, "t0_count_wr");
        rd(12'h004, 32'h1122AB44, 2'b00, "t0_count_ro");
        wr(12'h008, 32'h3, 4'b1110, 2'b00, "t0_ctrl_nostrb");
        rd(12'h008, 32'd0, 2'b00, "t0_ctrl_unchanged");

`ifdef IO_TIMER_PRESCALE_EN
        wr(12'h040, 32'd3, 4'hF, 2'b00, "pre_wr");
        p0 = w_cyc;
        rd(12'h040, 32'd3, 2'b00, "pre_rd");
        wr(12'h020, 32'd2, 4'hF, 2'b00, "t2_load_pre");
        wr(12'h028, 32'd1, 4'hF, 2'b00, "t2_en_pre");
        c0 = w_cyc;
        t1 = p0 + 4;
        while (t1 <= c0) t1 += 4;
        wait_irq(2, 30, got);
        chk("t2_prescaled_expiry", 32'(got), 32'(t1 + 4));
`else
        rd(12'h040, 32'd0, 2'b10, "pre_unmapped_rd");
        wr(12'h040, 32'd3, 4'hF, 2'b10, "pre_unmapped_wr");
`endif

        // Reset in the middle of pending read and write responses
        wr(12'h030, 32'd1, 4'hF, 2'b00, "t3_load1");
        wr(12'h038, 32'd1, 4'hF, 2'b00, "t3_en");
        wait_irq(3, 10, got);
        s_axi_awaddr = 32'h000; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        s_axi_araddr = 32'h030; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        #1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        chk("pend_bvalid", {31'b0, s_axi_bvalid}, 32'd1);
        chk("pend_rvalid", {31'b0, s_axi_rvalid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
        chk("mid_rst_rvalid", {31'b0, s_axi_rvalid}, 32'd0);
        chk("mid_rst_rdata", s_axi_rdata, 32'd0);
        chk("mid_rst_irq", {28'b0, timer_irq}, 32'd0);
        tick(2);
        reset = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("post_rst_no_bvalid", {31'b0, s_axi_bvalid}, 32'd0);
            chk("post_rst_no_rvalid", {31'b0, s_axi_rvalid}, 32'd0);
        end
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        rd(12'h030, 32'd0, 2'b00, "post_rst_load3");
        rd(12'h038, 32'd0, 2'b00, "post_rst_ctrl3");
        rd(12'h03C, 32'd0, 2'b00, "post_rst_status3");
        rd(12'h000, 32'd0, 2'b00, "post_rst_load0");
        rd(12'h014, 32'd0, 2'b00, "post_rst_count1");
`ifdef IO_TIMER_PRESCALE_EN
        rd(12'h040, 32'd0, 2'b00, "post_rst_prescale");
`endif
        chk("post_rst_irq", {28'b0, timer_irq}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
